// File: rtl/serial_mag_cmp.sv
// ----------------------------------------------------------------------------
// serial_mag_cmp
//
// Bit-serial, MSB-first magnitude comparator controller. A start in IDLE
// latches two WIDTH-bit operands. One bit pair per cycle then goes out to an
// external 1-bit comparator cell, and the cell's combinational lt/gt/eq flags
// are folded into a registered a<b / a>b / a==b result. A one-cycle done
// pulse marks the moment the result becomes valid.
//
// Build option:
//   SERIAL_MAG_CMP_EARLY_EXIT_EN  defined   -> scan stops at the first
//                                              decisive bit
//                                 undefined -> constant-time scan of all WIDTH
//                                              bits, first decisive bit is
//                                              kept sticky
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   compare request, sampled only in IDLE
//   a_in     in   operand A (WIDTH), latched on accepted start
//   b_in     in   operand B (WIDTH), latched on accepted start
//   cmp_a    out  current bit of latched A to the 1-bit cell (0 outside SCAN)
//   cmp_b    out  current bit of latched B to the 1-bit cell (0 outside SCAN)
//   cmp_lt   in   cell flag cmp_a < cmp_b (same-cycle return)
//   cmp_gt   in   cell flag cmp_a > cmp_b
//   cmp_eq   in   cell flag cmp_a == cmp_b
//   busy     out  high while scanning
//   done     out  one-cycle pulse when the result becomes valid
//   a_lt_b   out  registered result
//   a_gt_b   out  registered result
//   a_eq_b   out  registered result
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; result outputs hold the last compare
// SCAN  | one operand bit pair per cycle, MSB first
// DONE  | result valid, done pulse for one cycle
// ----------------------------------------------------------------------------
module serial_mag_cmp #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             cmp_a,
    output logic             cmp_b,
    input  logic             cmp_lt,
    input  logic             cmp_gt,
    input  logic             cmp_eq,
    output logic             busy,
    output logic             done,
    output logic             a_lt_b,
    output logic             a_gt_b,
    output logic             a_eq_b
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    // Result encoding {lt, gt, eq}
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_LT   = 3'b100;
    localparam logic [2:0] RES_GT   = 3'b010;
    localparam logic [2:0] RES_EQ   = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [IDX_W-1:0] idx;
    logic [2:0]       res;
    logic [2:0]       res_final;

    logic             accept;
    logic             last_bit;
    logic             decisive;
    logic             bit_eq;
    logic [2:0]       bit_res;
    logic             scan_exit;

`ifndef SERIAL_MAG_CMP_EARLY_EXIT_EN
    // First decisive bit seen during a constant-time scan. Kept apart from
    // the output register so the outputs change only at the final edge.
    logic [2:0]       sticky;
`endif

    // ------------------------------------------------------------------
    // Cell flag resolution: gt wins over lt; no flag at all counts as an
    // equal bit, so bit_eq is also set when the cell reports nothing.
    // ------------------------------------------------------------------
    always_comb begin
        bit_res = RES_NONE;
        if (cmp_gt) begin
            bit_res = RES_GT;
        end else if (cmp_lt) begin
            bit_res = RES_LT;
        end
    end

    assign decisive = cmp_gt | cmp_lt;
    assign bit_eq   = cmp_eq | ~decisive;
    assign last_bit = (idx == '0);
    assign accept   = (state == IDLE) && start;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
`ifdef SERIAL_MAG_CMP_EARLY_EXIT_EN
                if (decisive || (last_bit && bit_eq)) begin
                    state_nxt = DONE;
                end
`else
                if (last_bit) begin
                    state_nxt = DONE;
                end
`endif
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign scan_exit = (state == SCAN) && (state_nxt == DONE);

    // ------------------------------------------------------------------
    // Result to register on the deciding edge
    // ------------------------------------------------------------------
    always_comb begin
        res_final = RES_EQ;
`ifdef SERIAL_MAG_CMP_EARLY_EXIT_EN
        if (decisive) begin
            res_final = bit_res;
        end
`else
        if (sticky != RES_NONE) begin
            res_final = sticky;
        end else if (decisive) begin
            res_final = bit_res;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
        end else if (accept) begin
            a_reg <= a_in;
            b_reg <= b_in;
        end
    end

    // idx stops at zero; SCAN always leaves from idx==0 at the latest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (accept) begin
            idx <= IDX_TOP;
        end else if ((state == SCAN) && !last_bit) begin
            idx <= idx - 1'b1;
        end
    end

`ifndef SERIAL_MAG_CMP_EARLY_EXIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky <= RES_NONE;
        end else if (accept) begin
            sticky <= RES_NONE;
        end else if ((state == SCAN) && (sticky == RES_NONE) && decisive) begin
            sticky <= bit_res;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res <= RES_NONE;
        end else if (accept) begin
            res <= RES_NONE;
        end else if (scan_exit) begin
            res <= res_final;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        cmp_a = 1'b0;
        cmp_b = 1'b0;
        case (state)
            SCAN: begin
                busy  = 1'b1;
                cmp_a = a_reg[idx];
                cmp_b = b_reg[idx];
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign a_lt_b = res[2];
    assign a_gt_b = res[1];
    assign a_eq_b = res[0];

endmodule

// File: tb/tb_serial_mag_cmp.sv
module tb_serial_mag_cmp;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         cmp_a, cmp_b;
    logic         cmp_lt, cmp_gt, cmp_eq;
    logic         busy, done, a_lt_b, a_gt_b, a_eq_b;

    int total = 0;
    int bad   = 0;

    // 1-bit cell model with override knobs
    logic force_lt   = 1'b0;
    logic force_none = 1'b0;
    int   force_idx  = -1;
    int   cur_m      = -1;

    always #5 clk = ~clk;

    always_comb begin
        cmp_lt = ~cmp_a & cmp_b;
        cmp_gt = cmp_a & ~cmp_b;
        cmp_eq = ~(cmp_a ^ cmp_b);
        if (force_none) begin
            cmp_lt = 1'b0;
            cmp_gt = 1'b0;
            cmp_eq = 1'b0;
        end
        if (force_lt && ((force_idx < 0) || (cur_m == W - 1 - force_idx)))
            cmp_lt = 1'b1;
    end

    serial_mag_cmp #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_lt(cmp_lt), .cmp_gt(cmp_gt),
        .cmp_eq(cmp_eq), .busy(busy), .done(done), .a_lt_b(a_lt_b),
        .a_gt_b(a_gt_b), .a_eq_b(a_eq_b)
    );

    // ---------------- reference model ----------------
    function automatic logic [2:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a < b) return 3'b100;
        if (a > b) return 3'b010;
        return 3'b001;
    endfunction

    // Scan cycles until done: first differing bit k costs W-k cycles.
    function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SERIAL_MAG_CMP_EARLY_EXIT_EN
        int x;
        int top;
        x = int'(a ^ b);
        if (x == 0) return W;
        top = 0;
        while ((x >> (top + 1)) != 0) top++;
        return W - top;
`else
        return W;
`endif
    endfunction

    function automatic logic [W-1:0] top_mask(input int lat);
        logic [W-1:0] m;
        m = '0;
        for (int i = 0; i < lat && i < W; i++) m[W-1-i] = 1'b1;
        return m;
    endfunction

    // ---------------- driver (observes, does not judge) ----------------
    task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input int inject_m,
                           output int lat, output logic [2:0] res, output logic [2:0] res_m0,
                           output logic [W-1:0] seen_a, output logic [W-1:0] seen_b,
                           output int busy_cnt, output logic done_after);
        @(negedge clk);
        a_in = a;
        b_in = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a_in = W'($urandom);
        b_in = W'($urandom);
        lat = -1;
        res = '0;
        seen_a = '0;
        seen_b = '0;
        busy_cnt = 0;
        done_after = 1'b1;
        res_m0 = {a_lt_b, a_gt_b, a_eq_b};
        for (int m = 0; m <= W + 2; m++) begin
            cur_m = m;
            if (m == inject_m) begin
                start = 1'b1;
                a_in = '1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = m;
                res = {a_lt_b, a_gt_b, a_eq_b};
                break;
            end
            if (busy) begin
                busy_cnt++;
                if (m < W) begin
                    seen_a[W-1-m] = cmp_a;
                    seen_b[W-1-m] = cmp_b;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        cur_m = -1;
        if (lat >= 0) begin
            @(negedge clk);
            done_after = done;
        end
    endtask

    // ---------------- scenarios ----------------
    int           lat, bcnt;
    logic [2:0]   res, res0;
    logic [W-1:0] sa, sb;
    logic         dafter;

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, a_lt_b, a_gt_b, a_eq_b, cmp_a, cmp_b} !== 7'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=0000000", {busy, done, a_lt_b, a_gt_b, a_eq_b, cmp_a, cmp_b});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_cmp(8'h10, 8'h01, -1, lat, res, res0, sa, sb, bcnt, dafter);
        total++;
        if (res !== 3'b010 || lat !== ref_lat(8'h10, 8'h01)) begin
            bad++;
            $display("FAIL reset_first_cmp got res=%b lat=%0d exp res=010 lat=%0d", res, lat, ref_lat(8'h10, 8'h01));
        end
        // reset in the middle of IDLE with a result held
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, a_lt_b, a_gt_b, a_eq_b, cmp_a, cmp_b} !== 7'b0) begin
            bad++;
            $display("FAIL reset_idle_outputs got=%b exp=0000000", {busy, done, a_lt_b, a_gt_b, a_eq_b, cmp_a, cmp_b});
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_cmp(8'h10, 8'h01, -1, lat, res, res0, sa, sb, bcnt, dafter);
        total++;
        if (res !== 3'b010 || lat !== ref_lat(8'h10, 8'h01) || dafter !== 1'b0) begin
            bad++;
            $display("FAIL reset_resume got res=%b lat=%0d done_after=%b exp res=010 lat=%0d done_after=0",
                     res, lat, dafter, ref_lat(8'h10, 8'h01));
        end
    endtask

    task automatic test_msb_gt();
        run_cmp(8'hA5, 8'h25, -1, lat, res, res0, sa, sb, bcnt, dafter);
        total++;
        if (sa[7] !== 1'b1 || sb[7] !== 1'b0) begin
            bad++;
            $display("FAIL msb_bits got cmp_a=%b cmp_b=%b exp cmp_a=1 cmp_b=0", sa[7], sb[7]);
        end
        total++;
        if (res !== 3'b010 || lat !== ref_lat(8'hA5, 8'h25)) begin
            bad++;
            $display("FAIL msb_gt got res=%b lat=%0d exp res=010 lat=%0d", res, lat, ref_lat(8'hA5, 8'h25));
        end
        total++;
        if (dafter !== 1'b0 || bcnt !== lat) begin
            bad++;
            $display("FAIL msb_gt_pulse got done_after=%b busy_cycles=%0d exp done_after=0 busy_cycles=%0d", dafter, bcnt, lat);
        end
    endtask

    task automatic test_lsb_lt_hold();
        run_cmp(8'h3C, 8'h3D, -1, lat, res, res0, sa, sb, bcnt, dafter);
        total++;
        if (res !== 3'b100 || lat !== ref_lat(8'h3C, 8'h3D) || bcnt !== W) begin
            bad++;
            $display("FAIL lsb_lt got res=%b lat=%0d busy=%0d exp res=100 lat=%0d busy=%0d",
                     res, lat, bcnt, ref_lat(8'h3C, 8'h3D), W);
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({a_lt_b, a_gt_b, a_eq_b, busy, done} !== 5'b10000) begin
                bad++;
                $display("FAIL lt_hold cycle=%0d got=%b exp=10000", i, {a_lt_b, a_gt_b, a_eq_b, busy, done});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_eq_then_lt();
        run_cmp(8'h7E, 8'h7E, -1, lat, res, res0, sa, sb, bcnt, dafter);
        total++;
        if (res !== 3'b001 || lat !== W) begin
            bad++;
            $display("FAIL eq_cmp got res=%b lat=%0d exp res=001 lat=%0d", res, lat, W);
        end
        run_cmp(8'h00, 8'hFF, -1, lat, res, res0, sa, sb, bcnt, dafter);
        total++;
        if (res0 !== 3'b000) begin
            bad++;
            $display("FAIL eq_cleared got=%b exp=000", res0);
        end
        total++;
        if (res !== 3'b100 || lat !== ref_lat(8'h00, 8'hFF)) begin
            bad++;
            $display("FAIL lt_after_eq got res=%b lat=%0d exp res=100 lat=%0d", res, lat, ref_lat(8'h00, 8'hFF));
        end
    endtask

    task automatic test_ignore_start();
        run_cmp(8'h01, 8'h02, 1, lat, res, res0, sa, sb, bcnt, dafter);
        total++;
        if (res !== 3'b100 || lat !== ref_lat(8'h01, 8'h02) || sa !== (8'h01 & top_mask(lat))) begin
            bad++;
            $display("FAIL ignore_start got res=%b lat=%0d seen_a=%h exp res=100 lat=%0d seen_a=%h",
                     res, lat, sa, ref_lat(8'h01, 8'h02), 8'h01 & top_mask(ref_lat(8'h01, 8'h02)));
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL ignore_start_idle got busy=%b exp busy=0", busy);
        end
    endtask

    task automatic test_reset_mid_scan();
        @(negedge clk);
        a_in = 8'h01;
        b_in = 8'h02;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_scan_busy got busy=%b exp busy=1", busy);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, a_lt_b, a_gt_b, a_eq_b, cmp_a, cmp_b} !== 7'b0) begin
            bad++;
            $display("FAIL mid_scan_reset got=%b exp=0000000", {busy, done, a_lt_b, a_gt_b, a_eq_b, cmp_a, cmp_b});
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL mid_scan_held got busy=%b done=%b exp busy=0 done=0", busy, done);
        end
        rst_n = 1'b1;
        run_cmp(8'hC3, 8'hC3, -1, lat, res, res0, sa, sb, bcnt, dafter);
        total++;
        if (res !== 3'b001 || lat !== W) begin
            bad++;
            $display("FAIL post_reset_cmp got res=%b lat=%0d exp res=001 lat=%0d", res, lat, W);
        end
    endtask

    task automatic test_flag_priority();
        int exp_lat;
        // lt forced at every bit; gt at bit 7 must still win
        force_lt = 1'b1;
        force_idx = -1;
        run_cmp(8'h80, 8'h00, -1, lat, res, res0, sa, sb, bcnt, dafter);
        force_lt = 1'b0;
`ifdef SERIAL_MAG_CMP_EARLY_EXIT_EN
        exp_lat = 1;
`else
        exp_lat = W;
`endif
        total++;
        if (res !== 3'b010 || lat !== exp_lat) begin
            bad++;
            $display("FAIL gt_over_lt got res=%b lat=%0d exp res=010 lat=%0d", res, lat, exp_lat);
        end
        // lt forced only at idx 3 after gt was already decided at idx 7
        force_lt = 1'b1;
        force_idx = 3;
        run_cmp(8'hA5, 8'h25, -1, lat, res, res0, sa, sb, bcnt, dafter);
        total++;
        if (res !== 3'b010 || lat !== ref_lat(8'hA5, 8'h25)) begin
            bad++;
            $display("FAIL sticky_gt got res=%b lat=%0d exp res=010 lat=%0d", res, lat, ref_lat(8'hA5, 8'h25));
        end
        // equal operands, lt forced at idx 3 only
        run_cmp(8'h55, 8'h55, -1, lat, res, res0, sa, sb, bcnt, dafter);
        force_lt = 1'b0;
        force_idx = -1;
`ifdef SERIAL_MAG_CMP_EARLY_EXIT_EN
        exp_lat = (W - 1 - 3) + 1;
`else
        exp_lat = W;
`endif
        total++;
        if (res !== 3'b100 || lat !== exp_lat) begin
            bad++;
            $display("FAIL forced_lt got res=%b lat=%0d exp res=100 lat=%0d", res, lat, exp_lat);
        end
        // no flags at all: every bit counts as equal
        force_none = 1'b1;
        run_cmp(8'hF0, 8'h0F, -1, lat, res, res0, sa, sb, bcnt, dafter);
        force_none = 1'b0;
        total++;
        if (res !== 3'b001 || lat !== W) begin
            bad++;
            $display("FAIL no_flags got res=%b lat=%0d exp res=001 lat=%0d", res, lat, W);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        int sel;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            sel = int'($urandom_range(0, 3));
            if (sel == 0) b = a;
            else if (sel == 1) b = a ^ W'(1 << $urandom_range(0, W - 1));
            else b = W'($urandom);
            run_cmp(a, b, -1, lat, res, res0, sa, sb, bcnt, dafter);
            total++;
            if (res !== ref_res(a, b) || lat !== ref_lat(a, b) || res0 !== 3'b000) begin
                bad++;
                $display("FAIL rand_result a=%h b=%h got res=%b lat=%0d start_res=%b exp res=%b lat=%0d start_res=000",
                         a, b, res, lat, res0, ref_res(a, b), ref_lat(a, b));
            end
            total++;
            if (sa !== (a & top_mask(ref_lat(a, b))) || sb !== (b & top_mask(ref_lat(a, b)))
                || bcnt !== ref_lat(a, b) || dafter !== 1'b0) begin
                bad++;
                $display("FAIL rand_scan a=%h b=%h got bits=%h/%h busy=%0d done_after=%b exp bits=%h/%h busy=%0d done_after=0",
                         a, b, sa, sb, bcnt, dafter, a & top_mask(ref_lat(a, b)),
                         b & top_mask(ref_lat(a, b)), ref_lat(a, b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_msb_gt();
        test_lsb_lt_hold();
        test_eq_then_lt();
        test_ignore_start();
        test_reset_mid_scan();
        test_flag_priority();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_mag_cmp.md
# serial_mag_cmp

Bit-serial, MSB-first magnitude comparator controller for WIDTH-bit operands. It sits directly upstream of the single-bit comparator cell. Each cycle it drives one operand bit pair into the cell and consumes the cell's combinational lt/gt/eq flags. From those flags it resolves and registers a multi-bit a<b / a>b / a==b result behind a start/done handshake.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request a compare; sampled only in IDLE.
- a_in  input  WIDTH  operand A; latched on an accepted start.
- b_in  input  WIDTH  operand B; latched on an accepted start.
- cmp_a  output  1  current bit of latched A, driven to the 1-bit cell.
- cmp_b  output  1  current bit of latched B, driven to the 1-bit cell.
- cmp_lt  input  1  cell flag: cmp_a < cmp_b, combinational return in the same cycle.
- cmp_gt  input  1  cell flag: cmp_a > cmp_b.
- cmp_eq  input  1  cell flag: cmp_a == cmp_b.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse when the result becomes valid.
- a_lt_b  output  1  registered result.
- a_gt_b  output  1  registered result.
- a_eq_b  output  1  registered result.

## Operation
- State machine states:
  - IDLE: wait for start=1. On an accepted start, latch a_in/b_in, set idx=WIDTH-1, clear the result register, and go to SCAN.
  - SCAN: drive cmp_a=a_reg[idx] and cmp_b=b_reg[idx]. At the edge, evaluate the flags:
    - cmp_gt=1: result {lt,gt,eq}=010; go to DONE.
    - cmp_lt=1: result 100; go to DONE.
    - cmp_eq=1 and idx==0: result 001; go to DONE.
    - otherwise: idx decrements; stay in SCAN.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Flag priority when the flags are not one-hot: gt > lt > eq. If all three are 0, treat the bit as equal.
- Result outputs hold their value through IDLE until the next accepted start clears them.
- idx is $clog2(WIDTH) bits and never wraps: SCAN always exits at idx==0.
- Outside SCAN, cmp_a and cmp_b are driven to 0.
- start in SCAN or DONE is ignored. Operand inputs are ignored except at the accepting edge.
- Reset assertion at any time, including mid-SCAN, returns the block to IDLE immediately and zeroes all outputs.

## Timing
- Reset value of every output: busy=0, done=0, a_lt_b=0, a_gt_b=0, a_eq_b=0, cmp_a=0, cmp_b=0.
- Start is accepted at edge E0. busy=1 from E0 until the deciding edge.
- With early exit, the first differing bit at position k is decided at edge E0+(WIDTH-k). Equal operands are decided at E0+WIDTH.
- At the deciding edge: results are updated, busy=0, done=1. done=0 at the following edge.
- Earliest next accepted start is the edge after done falls. Minimum throughput is one compare per WIDTH+2 cycles.

## Configuration
- SERIAL_MAG_CMP_EARLY_EXIT_EN defined:
  - SCAN terminates at the first decisive bit, as described above.
  - Latency varies from 1 to WIDTH scan cycles.
- Undefined (constant-time mode):
  - SCAN always runs all WIDTH cycles, down to idx==0.
  - The first decisive flag is captured into a sticky result. Later bits do not change it.
  - If no bit was decisive by idx==0, the result is 001.
  - done is always asserted at E0+WIDTH, regardless of the operands.

## Test plan
1. Assert rst_n=0 mid-idle, then release -> all outputs 0 and busy=0. After release, start with a=0x10, b=0x01 -> normal operation resumes.
2. WIDTH=8, macro defined, start with a=0xA5, b=0x25 -> cmp_a=1 and cmp_b=0 at idx 7. At E0+1: a_gt_b=1, done=1, busy=0. done=0 at E0+2.
3. Macro defined, a=0x3C, b=0x3D -> 8 scan cycles. At E0+8: a_lt_b=1, done pulse. The result holds in IDLE for 5 further cycles.
4. a=0x7E, b=0x7E -> a_eq_b=1 and done at E0+8. Then start with a=0x00, b=0xFF -> a_lt_b=1 at the new E0+1, and a_eq_b is cleared.
5. Start a=0x01, b=0x02. Pulse start with a=0xFF at E0+2, and assert rst_n=0 at E0+4 in a second run:
   - First run: the mid-SCAN start is ignored; result a_lt_b at E0+7.
   - Second run: busy and all results drop to 0 at the reset edge; the FSM is in IDLE.
6. Macro undefined, a=0xA5, b=0x25 -> busy stays high for 8 cycles. a_gt_b=1 and done at E0+8. Force cmp_lt=1 at idx 3 -> the result still reads gt.
